light_control: RTL and testbench

Occupancy- and ambient-light-driven controller for an interior light. It samples an 8-bit luminance sensor, an IR presence sensor, a motion sensor and a manual override switch, and drives one registered light-enable output. The light turns on only when the room is dark and occupied, stays on for a programmable hold time after occupancy ends, and can be forced on by the manual switch. It sits between the sensor front-end and the lamp driver.

---
 rtl/light_control.sv | 113 +++++++++++
 tb/tb_light_control.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/light_control.sv
// light_control: occupancy- and luminance-driven interior light controller.
// Sensors are registered first; a four-state FSM (IDLE/ON/HOLD/MANUAL)
// decides the light, and int_light is registered from the next state so it
// changes on the same edge as the state register.
module light_control #(
  parameter int DARK_TH     = 64,
  parameter int BRIGHT_TH   = 96,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lum_sen,
  input  logic       ir_sen,
  input  logic       motion_sen,
  input  logic       manual,
  output logic       int_light,
  output logic [1:0] o_state_dbg
);

  // Counter only needs to hold HOLD_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [7:0]       DARK_L    = 8'(DARK_TH);
  localparam logic [7:0]       BRIGHT_L  = 8'(BRIGHT_TH);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON     = 2'd1,
    HOLD   = 2'd2,
    MANUAL = 2'd3
  } state_t;

  logic [7:0]       r_lum_s;
  logic             r_ir_s;
  logic             r_motion_s;
  logic             r_manual_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_hold_cnt;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_occ;
  logic             w_dark;
  logic             w_bright;

  // Dark is only consulted from IDLE and bright only from ON/HOLD, which
  // gives the hysteresis band DARK_TH..BRIGHT_TH-1.
  assign w_occ    = r_ir_s | r_motion_s;
  assign w_dark   = (r_lum_s < DARK_L);
  assign w_bright = (r_lum_s >= BRIGHT_L);

  assign o_state_dbg = r_state;

  // Next-state and hold-counter logic; manual beats everything, bright beats occupancy.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_hold_cnt;
    if (r_manual_s) begin
      w_state_next = MANUAL;
    end else begin
      case (r_state)
        MANUAL: w_state_next = IDLE;
        IDLE: begin
          if (w_dark && w_occ) w_state_next = ON;
        end
        ON: begin
          if (w_bright) begin
            w_state_next = IDLE;
          end else if (!w_occ) begin
            w_state_next = HOLD;
            w_cnt_next   = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (w_bright) begin
            w_state_next = IDLE;
          end else if (w_occ) begin
            w_state_next = ON;
          end else if (r_hold_cnt == '0) begin
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_hold_cnt - CNT_ONE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Input sampling, state register and registered light output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lum_s    <= 8'd0;
      r_ir_s     <= 1'b0;
      r_motion_s <= 1'b0;
      r_manual_s <= 1'b0;
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      int_light  <= 1'b0;
    end else begin
      r_lum_s    <= lum_sen;
      r_ir_s     <= ir_sen;
      r_motion_s <= motion_sen;
      r_manual_s <= manual;
      r_state    <= w_state_next;
      r_hold_cnt <= w_cnt_next;
      int_light  <= (w_state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_light_control.sv
// tb_light_control: directed test-plan steps followed by randomized stimulus,
// every edge compared against a timestamp-based reference model.
module tb_light_control;

  localparam int DARK_TH     = 64;
  localparam int BRIGHT_TH   = 96;
  localparam int HOLD_CYCLES = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lum_sen;
  logic       ir_sen;
  logic       motion_sen;
  logic       manual;
  logic       int_light;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  light_control #(
    .DARK_TH    (DARK_TH),
    .BRIGHT_TH  (BRIGHT_TH),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lum_sen    (lum_sen),
    .ir_sen     (ir_sen),
    .motion_sen (motion_sen),
    .manual     (manual),
    .int_light  (int_light),
    .o_state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the light is "lit" by darkness+occupancy and stays lit
  // until bright, or until HOLD_CYCLES edges have elapsed since the edge at
  // which the sampled occupancy was first seen absent. Manual is a separate
  // flag that forces the light and clears "lit" when it is released.
  logic [7:0] m_lum;
  logic       m_occ;
  logic       m_mansmp;
  logic       m_man;
  logic       m_lit;
  int         m_drop;
  int         m_edge;

  task automatic model_edge(input logic rst, input logic man, input logic [7:0] lum,
                            input logic ir, input logic mo);
    m_edge++;
    if (rst) begin
      m_man = 1'b0; m_lit = 1'b0; m_drop = -1;
      m_lum = 8'd0; m_occ = 1'b0; m_mansmp = 1'b0;
    end else begin
      if (m_mansmp) begin
        m_man = 1'b1;
      end else if (m_man) begin
        m_man = 1'b0;
        m_lit = 1'b0;
      end else if (!m_lit) begin
        if (int'(m_lum) < DARK_TH && m_occ) begin
          m_lit  = 1'b1;
          m_drop = -1;
        end
      end else if (int'(m_lum) >= BRIGHT_TH) begin
        m_lit = 1'b0;
      end else if (m_occ) begin
        m_drop = -1;
      end else begin
        if (m_drop < 0) m_drop = m_edge;
        if (m_edge - m_drop >= HOLD_CYCLES) m_lit = 1'b0;
      end
      m_lum = lum; m_occ = ir | mo; m_mansmp = man;
    end
    exp_q.push_back(m_man | m_lit);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed int_light=%b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic man, input logic [7:0] lum,
                      input logic ir, input logic mo);
    logic e;
    reset = rst; manual = man; lum_sen = lum; ir_sen = ir; motion_sen = mo;
    @(posedge clk);
    model_edge(rst, man, lum, ir, mo);
    #1;
    e = exp_q.pop_front();
    check("model", int_light, e);
  endtask

  // ---------------- stimulus ----------------
  int lit_edges;
  logic [7:0] r_lum;
  logic r_ir, r_mo;

  initial begin
    m_edge = 0; m_drop = -1; m_lit = 1'b0; m_man = 1'b0;
    m_lum = 8'd0; m_occ = 1'b0; m_mansmp = 1'b0;
    reset = 1'b1; manual = 1'b0; lum_sen = 8'd0; ir_sen = 1'b0; motion_sen = 1'b0;
    #2;

    // Reset with manual asserted and a dark occupied room: light stays off.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'h01, 1, 0);
      check("reset_off", int_light, 1'b0);
    end
    step(0, 1, 8'h01, 1, 0);
    check("post_reset_e1", int_light, 1'b0);
    step(0, 1, 8'h01, 1, 0);
    check("post_reset_e2", int_light, 1'b1);

    // Release manual, then a bright occupied room keeps the light off.
    for (int i = 0; i < 7; i++) step(0, 0, 8'h80, 1, 1);
    check("bright_off", int_light, 1'b0);
    step(0, 0, 8'h08, 1, 1);
    step(0, 0, 8'h08, 1, 1);
    check("dark_on", int_light, 1'b1);

    // Hold timer: light stays on exactly HOLD_CYCLES edges from ON->HOLD.
    step(0, 0, 8'h08, 0, 0);
    check("drop_sample", int_light, 1'b1);
    lit_edges = 0;
    for (int i = 0; i < HOLD_CYCLES + 4; i++) begin
      step(0, 0, 8'h08, 0, 0);
      if (int_light === 1'b1) lit_edges++;
    end
    n_checks++;
    assert (lit_edges == HOLD_CYCLES) begin
      n_pass++;
    end else begin
      $error("FAIL hold_len: observed %0d lit edges expected %0d", lit_edges, HOLD_CYCLES);
    end
    check("hold_expired", int_light, 1'b0);

    // Re-occupancy during hold: no gap in the light.
    step(0, 0, 8'h08, 1, 1);
    step(0, 0, 8'h08, 1, 1);
    check("relight", int_light, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 8'h08, 0, 0);
      check("hold_no_gap", int_light, 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8'h08, 0, 1);
      check("reocc_no_gap", int_light, 1'b1);
    end

    // Hysteresis: 80 keeps on, 96 turns off, 80 does not turn back on.
    for (int i = 0; i < 4; i++) step(0, 0, 8'd80, 1, 0);
    check("hyst_keep_on", int_light, 1'b1);
    step(0, 0, 8'd96, 1, 0);
    check("bright_e1", int_light, 1'b1);
    step(0, 0, 8'd96, 1, 0);
    check("bright_e2", int_light, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'd80, 1, 0);
    check("hyst_keep_off", int_light, 1'b0);
    step(0, 0, 8'd63, 1, 0);
    step(0, 0, 8'd63, 1, 0);
    check("dark_th_minus1", int_light, 1'b1);
    step(0, 0, 8'd95, 0, 1);
    step(0, 0, 8'd95, 0, 1);
    check("bright_th_minus1", int_light, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'd96, 0, 0);
    step(0, 0, 8'd64, 1, 1);
    step(0, 0, 8'd64, 1, 1);
    check("dark_th_exact", int_light, 1'b0);

    // Manual override in a bright empty room, then release.
    step(0, 1, 8'h80, 0, 0);
    step(0, 1, 8'h80, 0, 0);
    check("manual_on", int_light, 1'b1);
    step(0, 0, 8'h80, 0, 0);
    check("manual_rel_e1", int_light, 1'b1);
    step(0, 0, 8'h80, 0, 0);
    check("manual_rel_e2", int_light, 1'b0);

    // Manual release in a dark occupied room: off for one edge, then back on.
    step(0, 1, 8'h08, 1, 1);
    step(0, 1, 8'h08, 1, 1);
    step(0, 0, 8'h08, 1, 1);
    step(0, 0, 8'h08, 1, 1);
    check("manual_rel_dark", int_light, 1'b0);
    step(0, 0, 8'h08, 1, 1);
    check("relight_after_manual", int_light, 1'b1);

    // Reset pulse in HOLD: light off at once, hold time discarded.
    step(0, 0, 8'h08, 0, 0);
    step(0, 0, 8'h08, 0, 0);
    step(0, 0, 8'h08, 0, 0);
    check("in_hold", int_light, 1'b1);
    step(1, 0, 8'h08, 0, 0);
    check("mid_reset", int_light, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h08, 0, 0);
    check("after_mid_reset", int_light, 1'b0);
    step(0, 0, 8'h08, 1, 0);
    step(0, 0, 8'h08, 1, 0);
    check("idle_after_reset", int_light, 1'b1);

    // Randomized phase: luminance biased toward the thresholds, sensors with
    // some persistence, rare manual and reset.
    r_lum = 8'h10; r_ir = 1'b0; r_mo = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r_lum = 8'($urandom_range(0, 255));
          1: r_lum = 8'($urandom_range(DARK_TH - 2, DARK_TH + 2));
          2: r_lum = 8'($urandom_range(BRIGHT_TH - 2, BRIGHT_TH + 2));
          default: r_lum = 8'($urandom_range(0, DARK_TH - 1));
        endcase
      end
      if ($urandom_range(0, 7) == 0) r_ir = ~r_ir;
      if ($urandom_range(0, 5) == 0) r_mo = ~r_mo;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0), r_lum, r_ir, r_mo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
